res_writeback: RTL

RES_WRITEBACK -- requirements
Module: res_writeback

---
 rtl/res_writeback.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/res_writeback.sv
// res_writeback: collects serialized result words into a small input FIFO and packs them
// into wide write beats. Each beat carries PACK lanes of W = NUM_PEGS*DATA_TYPE bits,
// plus a per-lane strobe. The beat address starts at the job's base address and advances
// by one on every accepted beat.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   i_start         job start pulse; i_base_addr / i_num_words are sampled with it
//   i_data_valid    serialized result word valid (no backpressure); word on i_data_bus
//   o_wr_valid      write beat valid; i_wr_ready completes the handshake
//   o_wr_addr       beat address
//   o_wr_data       beat data, lane k at [k*W +: W]
//   o_wr_strb       per-lane valid mask
//   o_busy          job in progress
//   o_done          one-cycle job completion pulse
//   o_overflow      sticky flag: a word was dropped because the FIFO was full
module res_writeback #(
    parameter int unsigned NUM_PEGS   = 4,
    parameter int unsigned DATA_TYPE  = 16,
    parameter int unsigned PACK       = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic [ADDR_W-1:0]                   i_base_addr,
    input  logic [15:0]                         i_num_words,
    input  logic                                i_data_valid,
    input  logic [NUM_PEGS*DATA_TYPE-1:0]       i_data_bus,
    output logic                                o_wr_valid,
    input  logic                                i_wr_ready,
    output logic [ADDR_W-1:0]                   o_wr_addr,
    output logic [PACK*NUM_PEGS*DATA_TYPE-1:0]  o_wr_data,
    output logic [PACK-1:0]                     o_wr_strb,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_overflow
);

    localparam int unsigned W      = NUM_PEGS * DATA_TYPE;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e state_q, state_d;

    // Job bookkeeping
    logic [15:0]        num_words_q;
    logic [15:0]        in_cnt_q;
    logic               overflow_q;
    logic               done_q;

    // Input FIFO
    logic [W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [W-1:0]       fifo_rdata;

    // Lane accumulator and presented beat
    logic [PACK*W-1:0]  lane_data_q, lane_data_next;
    logic [LANE_W-1:0]  lane_cnt_q;
    logic [PACK-1:0]    strb_next;
    logic               wr_valid_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [PACK*W-1:0]  wr_data_q;
    logic [PACK-1:0]    wr_strb_q;

    logic start_ok, start_zero, fifo_empty, fifo_full;
    logic pop, push, drop, in_word, in_last, pop_last, lane_last, beat_close;
    logic handshake, job_end;

    assign start_ok   = i_start && (state_q == StIdle) && (i_num_words != 16'd0);
    assign start_zero = i_start && (state_q == StIdle) && (i_num_words == 16'd0);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_rdata = mem_q[rd_ptr_q];

    assign handshake  = wr_valid_q && i_wr_ready;
    assign pop        = !fifo_empty && (!wr_valid_q || i_wr_ready);

    assign in_word    = (state_q == StRun) && i_data_valid;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
    assign push       = in_word && (!fifo_full || pop);
    assign drop       = in_word && fifo_full && !pop;
    assign in_last    = in_word && ((in_cnt_q + 16'd1) == num_words_q);

    // Words land in the FIFO one cycle after being counted, so by the time the job's final
    // word can be popped the FSM is already in FLUSH and nothing else will be pushed.
    assign pop_last   = pop && (state_q == StFlush) && (count_q == CNT_W'(1));
    assign lane_last  = (lane_cnt_q == LANE_W'(PACK - 1));
    assign beat_close = pop && (lane_last || pop_last);

    // Everything received has been popped and packed; only the last beat may be pending.
    // Also covers a job whose words were all dropped.
    assign job_end    = (state_q == StFlush) && fifo_empty && (lane_cnt_q == '0) &&
                        (!wr_valid_q || i_wr_ready);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (in_last)  state_d = StFlush;
            StFlush: if (job_end)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = (state_q != StIdle);
    end

    // Next accumulator contents and strobe for the lane being filled by this pop
    always_comb begin
        lane_data_next = lane_data_q;
        lane_data_next[int'(lane_cnt_q) * W +: W] = fifo_rdata;
        strb_next = '0;
        for (int k = 0; k < int'(PACK); k++) begin
            strb_next[k] = (k <= int'(lane_cnt_q));
        end
    end

    // FIFO storage, not reset: contents are only read behind the reset pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_words_q <= '0;
            in_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lane_data_q <= '0;
            lane_cnt_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
        end else begin
            if (start_ok) begin
                num_words_q <= i_num_words;
                in_cnt_q    <= '0;
                overflow_q  <= 1'b0;
                wr_addr_q   <= i_base_addr;
            end
            if (in_word) begin
                in_cnt_q <= in_cnt_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end

            done_q <= job_end || start_zero;

            if (handshake) begin
                wr_valid_q <= 1'b0;
                wr_addr_q  <= wr_addr_q + ADDR_W'(1);
            end

            // Pop implies the beat slot is free (or being freed) this cycle, so a closing
            // beat can be loaded straight away.
            if (pop) begin
                if (beat_close) begin
                    wr_valid_q  <= 1'b1;
                    wr_data_q   <= lane_data_next;
                    wr_strb_q   <= strb_next;
                    lane_data_q <= '0;
                    lane_cnt_q  <= '0;
                end else begin
                    lane_data_q <= lane_data_next;
                    lane_cnt_q  <= lane_cnt_q + LANE_W'(1);
                end
            end
        end
    end

    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_strb  = wr_strb_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;

endmodule
